// File: rtl/pmem_arbiter_if.sv
// Line-transfer bus shared by the cache ports and the physical memory port.
// The master drives the request side; the slave returns resp/rdata.
interface pmem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [LINE_WIDTH-1:0] wdata;
    logic                  resp;
    logic [LINE_WIDTH-1:0] rdata;

    modport master (
        output read, write, address, wdata,
        input  resp, rdata
    );

    modport slave (
        input  read, write, address, wdata,
        output resp, rdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Arbitrates the I-cache and D-cache line ports onto the single physical memory port.
// The grant is held for the whole transfer, and the memory response is steered back to the granted cache.
module pmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned RR_MODE    = 0
) (
    input  logic           clk,
    input  logic           rst,
    pmem_arbiter_if.slave  i,
    pmem_arbiter_if.slave  d,
    pmem_arbiter_if.master pmem
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    localparam bit FIXED_PRIO = (RR_MODE == 0);

    state_t                state;
    logic                  last_d;
    logic                  rd_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    logic i_req;
    logic d_req;
    logic pick_d;

    assign i_req  = i.read | i.write;
    assign d_req  = d.read | d.write;
    // When both caches request, D wins unless round-robin says D went last.
    assign pick_d = d_req && (!i_req || FIXED_PRIO || !last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_d) begin
                        state   <= SERVE_D;
                        rd_q    <= d.read & ~d.write;
                        wr_q    <= d.write;
                        addr_q  <= d.address;
                        wdata_q <= d.wdata;
                    end else if (i_req) begin
                        state   <= SERVE_I;
                        rd_q    <= i.read & ~i.write;
                        wr_q    <= i.write;
                        addr_q  <= i.address;
                        wdata_q <= i.wdata;
                    end
                end
                SERVE_I: begin
                    if (pmem.resp) begin
                        state  <= IDLE;
                        rd_q   <= 1'b0;
                        wr_q   <= 1'b0;
                        last_d <= 1'b0;
                    end
                end
                SERVE_D: begin
                    if (pmem.resp) begin
                        state  <= IDLE;
                        rd_q   <= 1'b0;
                        wr_q   <= 1'b0;
                        last_d <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pmem.read    = rd_q;
    assign pmem.write   = wr_q;
    assign pmem.address = addr_q;
    assign pmem.wdata   = wdata_q;

    assign i.resp  = (state == SERVE_I) & pmem.resp;
    assign d.resp  = (state == SERVE_D) & pmem.resp;
    assign i.rdata = (state == SERVE_I) ? pmem.rdata : '0;
    assign d.rdata = (state == SERVE_D) ? pmem.rdata : '0;
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single 256-bit physical memory port between the instruction cache (I) and the data cache (D).
- Sits between the two cache line-fill/write-back ports and the `pmem_*` interface at the top level.
- Grants one requester at a time and holds the grant until that transfer completes.
- Registers the forwarded request, then steers the memory response back to the granted cache.

Parameters:
- ADDR_WIDTH, 32, width of line addresses.
- LINE_WIDTH, 256, width of a cache line / memory burst data word.
- RR_MODE, 0. 0 = fixed priority with D winning ties. 1 = round-robin, where the tie goes to the requester not served last.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- i_read  input  1  I-cache line read request
- i_write  input  1  I-cache line write request (tied 0 in current design, still supported)
- i_address  input  ADDR_WIDTH  I-cache line address
- i_wdata  input  LINE_WIDTH  I-cache write line
- i_resp  output  1  I transfer complete
- i_rdata  output  LINE_WIDTH  line returned to I-cache
- d_read  input  1  D-cache line read request
- d_write  input  1  D-cache line write-back request
- d_address  input  ADDR_WIDTH  D-cache line address
- d_wdata  input  LINE_WIDTH  D-cache write line
- d_resp  output  1  D transfer complete
- d_rdata  output  LINE_WIDTH  line returned to D-cache
- pmem_read  output  1  memory read strobe
- pmem_write  output  1  memory write strobe
- pmem_address  output  ADDR_WIDTH  memory line address
- pmem_wdata  output  LINE_WIDTH  memory write line
- pmem_resp  input  1  memory transfer complete
- pmem_rdata  input  LINE_WIDTH  memory read line

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high (`rst`, sampled on the rising edge of `clk`).
- Reset values:
  - state = IDLE.
  - pmem_read, pmem_write, i_resp, d_resp = 0.
  - pmem_address, pmem_wdata = 0.
  - last_served = I, so the first round-robin tie goes to D.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - A requester is "requesting" when its read or write is 1.
  - If both request:
    - RR_MODE=0: grant D.
    - RR_MODE=1: grant the one not equal to last_served.
  - If only one requests, grant it.
  - On grant, capture the granted requester's address, wdata and read/write into the pmem output registers, and move to SERVE_x.
  - pmem_read/pmem_write therefore rise exactly 1 cycle after the request is first seen in IDLE.
  - If read and write are both 1 on the same requester, treat it as a write: pmem_write=1, pmem_read=0.
  - pmem_resp in IDLE is ignored.
- SERVE_x:
  - The pmem outputs hold stable. Requester input changes are not sampled.
  - x_rdata = pmem_rdata combinationally. The other requester's rdata is 0.
  - x_resp = pmem_resp combinationally, so the response reaches the cache in the same cycle as pmem_resp. The non-granted resp stays 0.
  - In the pmem_resp cycle: clear pmem_read/pmem_write, set last_served = x, and go to IDLE next cycle.
- Turnaround: IDLE always lasts at least 1 cycle between transfers.
  - Caches deassert read/write the cycle after resp, so a stale request is never re-granted.
  - A pending request from the other cache is granted in that IDLE cycle.
  - Back-to-back minimum: one transfer ends at cycle T (resp) and the next pmem strobe rises at T+2.
- Requester contract: once a requester asserts read/write, it holds the request, address and wdata until its resp. The arbiter does not need to re-sample them.
- Starvation: with RR_MODE=1, neither requester waits more than one other transfer. With RR_MODE=0, I may wait indefinitely under continuous D traffic (accepted).
- Reset mid-transfer: the next edge forces IDLE and clears the strobes. No resp is issued for the aborted transfer, and any later pmem_resp seen in IDLE is dropped.
- No combinational path from any requester input to any pmem_* output. All pmem_* outputs are registered.

Test Plan:
- Single I read: i_read=1, i_address=0x0000_0060; memory responds 4 cycles after the strobe with rdata=0xA5..A5.
  - pmem_read=1 and pmem_address=0x60 from cycle 1.
  - i_resp=1 and i_rdata=0xA5..A5 in the pmem_resp cycle.
  - d_resp stays 0.
- Simultaneous requests, RR_MODE=0: i_read=1 @0x100 and d_write=1 @0x200 with wdata=0x1234..., asserted in the same cycle.
  - The D write is issued first: pmem_write=1, address 0x200, wdata forwarded.
  - After d_resp, one IDLE cycle, then the I read of 0x100 is issued.
- Round-robin, RR_MODE=1: both requesters assert continuously for 4 transfers.
  - Grant order is D, I, D, I.
  - Each resp is delivered only to the matching cache.
- Stability under input change: during SERVE_D, change d_address to 0x300 and assert i_read.
  - pmem_address stays 0x200 until resp.
  - The I request is granted only after IDLE.
- Reset mid-transfer: assert rst 2 cycles into SERVE_I, then pulse pmem_resp after reset.
  - pmem_read=0 on the cycle after rst.
  - i_resp never asserts, and state remains IDLE.
- Spurious response: pmem_resp=1 in IDLE with no requests.
  - i_resp=0 and d_resp=0.
  - No state change.
